pipe_hazard_ctrl: RTL and testbench

Parametrised hazard and pipeline-control unit for the five-stage (F/D/E/M/W) RV32I core. It tracks the register footprint of in-flight instructions in its own E/M/W shadow registers, so the top level only supplies decode-stage fields. From that state it generates per-stage stall and flush controls and the E-stage forwarding selects. It also holds the pipeline for a multi-cycle data memory.

---
 rtl/pipe_hazard_pkg.sv | 47 ++++
 rtl/pipe_hazard_ctrl_if.sv | 38 +++
 rtl/pipe_hazard_ctrl_mem_wait_ctr.sv | 37 +++
 rtl/pipe_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_pkg.sv
// Shared types for the RV32I hazard unit: forward-select encoding and E/M/W shadow entries.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package pipe_hazard_pkg;

  // Register-specifier width used by the shadow entries and as the default for the unit.
  localparam int REG_ADDR_WIDTH_DFLT = 5;

  typedef logic [REG_ADDR_WIDTH_DFLT-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_e;

  // Instruction sitting in E: sources are needed for forwarding, rd/flags for hazards.
  typedef struct packed {
    logic      vld;
    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
    logic      regwrite;
    logic      load;
  } e_entry_t;

  typedef struct packed {
    logic      vld;
    reg_addr_t rd;
    logic      regwrite;
    logic      load;
  } m_entry_t;

  typedef struct packed {
    logic      vld;
    reg_addr_t rd;
    logic      regwrite;
  } w_entry_t;

  // Picks the youngest in-flight producer of src; M wins over W, x0 never forwards.
  function automatic fwd_sel_e fwd_pick(input reg_addr_t src, input m_entry_t m, input w_entry_t w);
    if (m.vld && m.regwrite && (m.rd != '0) && (m.rd == src)) return FWD_M;
    if (w.vld && w.regwrite && (w.rd != '0) && (w.rd == src)) return FWD_W;
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-stage footprint in, per-stage stall/flush and E-stage forward selects out.
// Latency: n/a (wires only).
// Backpressure: n/a; stalls travel as plain level signals on this bundle.
interface pipe_hazard_ctrl_if
  import pipe_hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DFLT
);
  logic [REG_ADDR_WIDTH-1:0] Rs1D_i;
  logic [REG_ADDR_WIDTH-1:0] Rs2D_i;
  logic [REG_ADDR_WIDTH-1:0] RdD_i;
  logic                      RegWriteD_i;
  logic                      LoadD_i;
  logic                      PCSrcE_i;
  logic                      StallF_o;
  logic                      StallD_o;
  logic                      StallE_o;
  logic                      StallM_o;
  logic                      FlushD_o;
  logic                      FlushE_o;
  logic                      FlushW_o;
  logic [1:0]                ForwardAE_o;
  logic [1:0]                ForwardBE_o;

  // Pipeline side: supplies decode fields, consumes controls.
  modport master (
    output Rs1D_i, Rs2D_i, RdD_i, RegWriteD_i, LoadD_i, PCSrcE_i,
    input  StallF_o, StallD_o, StallE_o, StallM_o, FlushD_o, FlushE_o, FlushW_o,
    input  ForwardAE_o, ForwardBE_o
  );

  // Hazard unit side.
  modport slave (
    input  Rs1D_i, Rs2D_i, RdD_i, RegWriteD_i, LoadD_i, PCSrcE_i,
    output StallF_o, StallD_o, StallE_o, StallM_o, FlushD_o, FlushE_o, FlushW_o,
    output ForwardAE_o, ForwardBE_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl_mem_wait_ctr.sv
// Loadable down-counter that holds the pipeline while a multi-cycle data-memory read completes.
// Latency: busy_o rises the cycle after load_i and stays high for load_val_i cycles.
// Backpressure: busy_o is the hold request; it cannot itself be stalled.
module mem_wait_ctr #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             busy_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Reload on a new load entering M, otherwise count down to zero and park.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register; reset drops busy immediately.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/pipeline control for the 5-stage RV32I core; optional forwarding via PIPE_HAZARD_FWD_EN.
// Latency: controls are combinational from E/M/W shadow state, wait counter and D inputs.
// Backpressure: load-use/interlock stalls F/D and bubbles E; memory wait freezes F..M and bubbles W.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DFLT,
  parameter int LOAD_LATENCY   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int CTR_W = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY) : 1;
  localparam logic [CTR_W-1:0] WAIT_LOAD = CTR_W'(LOAD_LATENCY - 1);
  localparam bit WAIT_EN = (LOAD_LATENCY > 1);

  logic [REG_ADDR_WIDTH-1:0] rs1_d, rs2_d, rd_d;
  e_entry_t e_q, e_d;
  m_entry_t m_q, m_d;
  w_entry_t w_q, w_d;
  logic     busy, load_en, hazard;
  logic     stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
  fwd_sel_e fwd_a, fwd_b;
  logic     unused_shadow;

  assign rs1_d = hz.Rs1D_i;
  assign rs2_d = hz.Rs2D_i;
  assign rd_d  = hz.RdD_i;

  // A valid load leaving E while nothing is frozen arms the wait for the remaining read cycles.
  assign load_en = WAIT_EN && !busy && e_q.vld && e_q.load;

  mem_wait_ctr #(.WIDTH(CTR_W)) u_wait (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load_en),
    .load_val_i (WAIT_LOAD),
    .busy_o     (busy)
  );

  // Hazard detection and forward selects; priority is memory wait, then branch, then data hazard.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
`ifdef PIPE_HAZARD_FWD_EN
    fwd_a  = fwd_pick(e_q.rs1, m_q, w_q);
    fwd_b  = fwd_pick(e_q.rs2, m_q, w_q);
    // Only a load in E cannot be forwarded in time.
    hazard = e_q.vld && e_q.load && (e_q.rd != '0) &&
             ((e_q.rd == rs1_d) || (e_q.rd == rs2_d));
`else
    fwd_a  = FWD_NONE;
    fwd_b  = FWD_NONE;
    // Without bypasses, wait until the producer reaches W (register file writes first).
    hazard = (e_q.vld && e_q.regwrite && (e_q.rd != '0) &&
              ((e_q.rd == rs1_d) || (e_q.rd == rs2_d))) ||
             (m_q.vld && m_q.regwrite && (m_q.rd != '0) &&
              ((m_q.rd == rs1_d) || (m_q.rd == rs2_d)));
`endif
    if (busy) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.PCSrcE_i) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (hazard) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // Shadow advance mirrors the real pipeline registers under the same stall/flush controls.
  always_comb begin
    e_d = e_q;
    m_d = m_q;
    w_d = '0;
    if (!busy) begin
      w_d = '{vld: m_q.vld, rd: m_q.rd, regwrite: m_q.regwrite};
      m_d = '{vld: e_q.vld, rd: e_q.rd, regwrite: e_q.regwrite, load: e_q.load};
      if (flush_e) begin
        e_d = '0;
      end else begin
        e_d = '{vld: 1'b1, rs1: rs1_d, rs2: rs2_d, rd: rd_d,
                regwrite: hz.RegWriteD_i, load: hz.LoadD_i};
      end
    end
  end

  // Shadow registers; bubbles are all-zero so stale specifiers never match.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  // Some shadow fields are kept for visibility but not consumed in every build.
  assign unused_shadow = ^{e_q, m_q, w_q};

  assign hz.StallF_o    = stall_f;
  assign hz.StallD_o    = stall_d;
  assign hz.StallE_o    = stall_e;
  assign hz.StallM_o    = stall_m;
  assign hz.FlushD_o    = flush_d;
  assign hz.FlushE_o    = flush_e;
  assign hz.FlushW_o    = flush_w;
  assign hz.ForwardAE_o = fwd_a;
  assign hz.ForwardBE_o = fwd_b;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: single-cycle memory unit driven from a per-cycle vector table,
// plus a three-cycle-memory unit for wait, reload, branch-during-wait and reset-mid-wait.
// Control vectors are packed {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] C0 = 7'b0000000;
  localparam logic [6:0] LU = 7'b1100010;
  localparam logic [6:0] BR = 7'b0000110;
  localparam logic [6:0] WT = 7'b1111001;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       pc;
    logic [6:0] ctrl;
    logic [3:0] fwd;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       rw, ld, pc;
  int         n_cmp = 0;
  int         n_bad = 0;
  vec_t       tbl[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_ADDR_WIDTH(5)) if1 ();
  pipe_hazard_ctrl_if #(.REG_ADDR_WIDTH(5)) if3 ();

  assign if1.Rs1D_i = rs1;
  assign if1.Rs2D_i = rs2;
  assign if1.RdD_i = rd;
  assign if1.RegWriteD_i = rw;
  assign if1.LoadD_i = ld;
  assign if1.PCSrcE_i = pc;
  assign if3.Rs1D_i = rs1;
  assign if3.Rs2D_i = rs2;
  assign if3.RdD_i = rd;
  assign if3.RegWriteD_i = rw;
  assign if3.LoadD_i = ld;
  assign if3.PCSrcE_i = pc;

  pipe_hazard_ctrl #(.REG_ADDR_WIDTH(5), .LOAD_LATENCY(1)) dut1 (
    .clk_i (clk),
    .rst_i (rst_n),
    .hz    (if1)
  );

  pipe_hazard_ctrl #(.REG_ADDR_WIDTH(5), .LOAD_LATENCY(3)) dut3 (
    .clk_i (clk),
    .rst_i (rst_n),
    .hz    (if3)
  );

  wire [6:0] ctrl1 = {if1.StallF_o, if1.StallD_o, if1.StallE_o, if1.StallM_o,
                      if1.FlushD_o, if1.FlushE_o, if1.FlushW_o};
  wire [3:0] fwd1  = {if1.ForwardAE_o, if1.ForwardBE_o};
  wire [6:0] ctrl3 = {if3.StallF_o, if3.StallD_o, if3.StallE_o, if3.StallM_o,
                      if3.FlushD_o, if3.FlushE_o, if3.FlushW_o};
  wire [3:0] fwd3  = {if3.ForwardAE_o, if3.ForwardBE_o};

  function automatic vec_t mk(input int a, input int b, input int d, input logic w,
                              input logic l, input logic p, input logic [6:0] c,
                              input logic [3:0] f);
    vec_t v;
    v.rs1 = 5'(a);
    v.rs2 = 5'(b);
    v.rd = 5'(d);
    v.rw = w;
    v.ld = l;
    v.pc = p;
    v.ctrl = c;
    v.fwd = f;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic drive(input int a, input int b, input int d, input logic w,
                       input logic l, input logic p);
    rs1 = 5'(a);
    rs2 = 5'(b);
    rd = 5'(d);
    rw = w;
    ld = l;
    pc = p;
  endtask

  // Reset both units from just after a rising edge; returns just after a rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] seq_exp[8];
    rst_n = 1'b0;
    drive(0, 0, 0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("reset ctrl1", {1'b0, ctrl1}, 8'h00);
    chk("reset fwd1", {4'h0, fwd1}, 8'h00);
    chk("reset ctrl3", {1'b0, ctrl3}, 8'h00);
    chk("reset fwd3", {4'h0, fwd3}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef PIPE_HAZARD_FWD_EN
    tbl.push_back(mk(1, 2, 5, 1, 0, 0, C0, 4'b0000));   // add x5,x1,x2
    tbl.push_back(mk(5, 3, 6, 1, 0, 0, C0, 4'b0000));   // sub x6,x5,x3
    tbl.push_back(mk(8, 9, 7, 1, 0, 0, C0, 4'b1000));   // sub in E: A from M
    tbl.push_back(mk(3, 6, 12, 1, 0, 0, C0, 4'b0000));  // or x12,x3,x6
    tbl.push_back(mk(1, 0, 5, 1, 1, 0, C0, 4'b0001));   // lw x5; or in E: B from W
    tbl.push_back(mk(5, 0, 6, 1, 0, 0, LU, 4'b0000));   // add x6,x5: load-use
    tbl.push_back(mk(5, 0, 6, 1, 0, 0, C0, 4'b0000));   // bubble in E
    tbl.push_back(mk(2, 0, 8, 1, 1, 0, C0, 4'b0100));   // add in E: A from W (lw)
    tbl.push_back(mk(8, 8, 9, 1, 0, 1, BR, 4'b0000));   // branch beats load-use
    tbl.push_back(mk(1, 2, 0, 1, 0, 0, C0, 4'b0000));   // add x0
    tbl.push_back(mk(0, 0, 14, 1, 0, 0, C0, 4'b0000));  // reads x0 behind x0 write
    tbl.push_back(mk(0, 0, 5, 1, 0, 0, C0, 4'b0000));   // x0 writer in M: no forward
    tbl.push_back(mk(1, 1, 5, 1, 0, 0, C0, 4'b0000));   // second write of x5
    tbl.push_back(mk(5, 5, 6, 1, 0, 0, C0, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, C0, 4'b1010));   // x5 in M and W: M wins
`else
    tbl.push_back(mk(1, 2, 5, 1, 0, 0, C0, 4'b0000));   // add x5,x1,x2
    tbl.push_back(mk(5, 3, 6, 1, 0, 0, LU, 4'b0000));   // sub x6,x5: E match
    tbl.push_back(mk(5, 3, 6, 1, 0, 0, LU, 4'b0000));   // M match
    tbl.push_back(mk(5, 3, 6, 1, 0, 0, C0, 4'b0000));   // W match is not a hazard
    tbl.push_back(mk(8, 9, 7, 1, 0, 0, C0, 4'b0000));
    tbl.push_back(mk(3, 6, 12, 1, 0, 0, LU, 4'b0000));  // x6 still in M
    tbl.push_back(mk(3, 6, 12, 1, 0, 0, C0, 4'b0000));
    tbl.push_back(mk(1, 0, 5, 1, 1, 0, C0, 4'b0000));   // lw x5
    tbl.push_back(mk(5, 0, 6, 1, 0, 0, LU, 4'b0000));
    tbl.push_back(mk(5, 0, 6, 1, 0, 0, LU, 4'b0000));
    tbl.push_back(mk(5, 0, 6, 1, 0, 0, C0, 4'b0000));
    tbl.push_back(mk(2, 0, 8, 1, 1, 0, C0, 4'b0000));   // lw x8
    tbl.push_back(mk(8, 8, 9, 1, 0, 1, BR, 4'b0000));   // branch beats interlock
    tbl.push_back(mk(1, 2, 0, 1, 0, 0, C0, 4'b0000));   // add x0
    tbl.push_back(mk(0, 0, 14, 1, 0, 0, C0, 4'b0000));  // x0 writer in E: no stall
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, C0, 4'b0000));   // x0 writer in M: no stall
`endif

    foreach (tbl[i]) begin
      drive(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].rw, tbl[i].ld, tbl[i].pc);
      @(negedge clk);
      chk($sformatf("row%0d ctrl", i), {1'b0, ctrl1}, {1'b0, tbl[i].ctrl});
      chk($sformatf("row%0d fwd", i), {4'h0, fwd1}, {4'h0, tbl[i].fwd});
      @(posedge clk);
      #1;
    end

    // Three-cycle memory: lw x5, lw x6 back to back, then an independent op.
    // Branch asserted from cycle 5 must only act once the second wait ends.
    do_reset();
    seq_exp = '{C0, C0, WT, WT, C0, WT, WT, BR};
    for (int c = 0; c < 8; c++) begin
      if (c == 0)      drive(1, 0, 5, 1'b1, 1'b1, 1'b0);
      else if (c == 1) drive(7, 0, 6, 1'b1, 1'b1, 1'b0);
      else             drive(1, 2, 20, 1'b1, 1'b0, (c >= 5));
      @(negedge clk);
      chk($sformatf("wait c%0d ctrl", c), {1'b0, ctrl3}, {1'b0, seq_exp[c]});
      chk($sformatf("wait c%0d fwd", c), {4'h0, fwd3}, 8'h00);
      @(posedge clk);
      #1;
    end

    // Reset dropped in the middle of a wait releases the stalls without a clock edge.
    do_reset();
    drive(1, 0, 5, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    drive(1, 2, 20, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rstwait busy", {1'b0, ctrl3}, {1'b0, WT});
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstwait async", {1'b0, ctrl3}, 8'h00);
    @(negedge clk);
    chk("rstwait held", {1'b0, ctrl3}, 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
